// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: frame receiver, E0/F0 decoder, held-key tracker and event FIFO.
// Optional macro PS2_TYPEMATIC_EN forwards auto-repeat makes into the event FIFO.
module ps2_key_tracker #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic [CNT_W-1:0] press_cnt,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             fifo_ovf,
  output logic             frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXTBRK} dec_state_e;

  // shift_q holds {parity, d[7:0], start}; stop is the bit sampled on the last edge
  function automatic logic frame_ok(input logic [9:0] sh, input logic stop_bit);
    return (sh[0] == 1'b0) && (stop_bit == 1'b1) && ((^sh[9:1]) == 1'b1);
  endfunction

  logic [2:0]       clk_sync_q, dat_sync_q;
  logic             fall_s, bit_s;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_q, byte_d;
  logic             frame_err_q, frame_err_d;
  dec_state_e       state_q, state_d;
  logic             evt_s, evt_ext_s, evt_brk_s, code_match_s;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d, key_down_q, key_down_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic             push_q, push_d;
  logic [9:0]       push_data_q, push_data_d;
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             pop_s, full_s, wr_s;
  logic             fifo_ovf_q, fifo_ovf_d;

  // Three-flop synchronisers for the asynchronous PS/2 lines
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= 3'b000;
      dat_sync_q <= 3'b000;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[1:0], ps2_data};
    end
  end

  assign fall_s = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_s  = dat_sync_q[2];

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = frame_err_q;
    if (fall_s) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (frame_ok(shift_q, bit_s)) begin
          byte_valid_d = 1'b1;
          byte_d       = shift_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {bit_s, shift_q[9:1]};
      end
    end else if (bit_cnt_q != 4'd0) begin
      // A stalled frame is abandoned so the next start bit realigns the receiver
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d   = 4'd0;
        to_cnt_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Decoder: prefix bytes steer the state, payload bytes emit make/break
  always_comb begin
    state_d   = state_q;
    evt_s     = 1'b0;
    evt_ext_s = 1'b0;
    evt_brk_s = 1'b0;
    if (byte_valid_q) begin
      if (byte_q == 8'hE0) begin
        state_d = ST_EXT;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (byte_q == 8'hF0) begin
              state_d = ST_BRK;
            end else begin
              evt_s = 1'b1;
            end
          end
          ST_EXT: begin
            if (byte_q == 8'hF0) begin
              state_d = ST_EXTBRK;
            end else begin
              evt_s     = 1'b1;
              evt_ext_s = 1'b1;
              state_d   = ST_IDLE;
            end
          end
          ST_BRK: begin
            evt_s     = 1'b1;
            evt_brk_s = 1'b1;
            state_d   = ST_IDLE;
          end
          ST_EXTBRK: begin
            evt_s     = 1'b1;
            evt_ext_s = 1'b1;
            evt_brk_s = 1'b1;
            state_d   = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  assign code_match_s = ({evt_ext_s, byte_q} == {key_ext_q, key_code_q});

  always_comb begin
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_down_d  = key_down_q;
    press_cnt_d = press_cnt_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    if (evt_s) begin
      if (evt_brk_s) begin
        push_d      = 1'b1;
        push_data_d = {evt_ext_s, 1'b1, byte_q};
        if (code_match_s) begin
          key_down_d = 1'b0;
        end else begin
          key_down_d = key_down_q;
        end
      end else if (key_down_q && code_match_s) begin
`ifdef PS2_TYPEMATIC_EN
        push_d      = 1'b1;
        push_data_d = {evt_ext_s, 1'b0, byte_q};
`else
        push_d      = 1'b0;
`endif
      end else begin
        key_code_d  = byte_q;
        key_ext_d   = evt_ext_s;
        key_down_d  = 1'b1;
        press_cnt_d = press_cnt_q + CNT_W'(1);
        push_d      = 1'b1;
        push_data_d = {evt_ext_s, 1'b0, byte_q};
      end
    end else begin
      push_d = 1'b0;
    end
  end

  assign pop_s  = (count_q != '0) && evt_ready;
  assign full_s = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign wr_s   = push_q && (!full_s || pop_s);

  always_comb begin
    fifo_ovf_d = fifo_ovf_q;
    count_d    = count_q;
    if (push_q && full_s && !pop_s) begin
      fifo_ovf_d = 1'b1;
    end else begin
      fifo_ovf_d = fifo_ovf_q;
    end
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Receiver, decoder, key tracker and FIFO control state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_q    <= 4'd0;
      shift_q      <= 10'd0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'd0;
      frame_err_q  <= 1'b0;
      state_q      <= ST_IDLE;
      key_code_q   <= 8'd0;
      key_ext_q    <= 1'b0;
      key_down_q   <= 1'b0;
      press_cnt_q  <= '0;
      push_q       <= 1'b0;
      push_data_q  <= 10'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fifo_ovf_q   <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_down_q   <= key_down_d;
      press_cnt_q  <= press_cnt_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      wr_ptr_q     <= wr_s  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q     <= pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q      <= count_d;
      fifo_ovf_q   <= fifo_ovf_d;
    end
  end

  // Storage is cleared on reset so the show-ahead head reads 0 while empty after reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
    end else if (wr_s) begin
      mem_q[wr_ptr_q] <= push_data_q;
    end
  end

  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_down  = key_down_q;
  assign press_cnt = press_cnt_q;
  assign evt_valid = (count_q != '0);
  assign evt_ext   = mem_q[rd_ptr_q][9];
  assign evt_break = mem_q[rd_ptr_q][8];
  assign evt_code  = mem_q[rd_ptr_q][7:0];
  assign fifo_ovf  = fifo_ovf_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: expected events queued at stimulus time, checked at each pop.
module tb_ps2_key_tracker;

  localparam int FIFO_DEPTH  = 8;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF        = 20;
`ifdef PS2_TYPEMATIC_EN
  localparam int T2_EVENTS = 4;
`else
  localparam int T2_EVENTS = 2;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             ps2_clk = 1'b1;
  logic             ps2_data = 1'b1;
  logic             evt_ready = 1'b0;
  logic [7:0]       key_code, evt_code;
  logic             key_ext, key_down, evt_valid, evt_ext, evt_break, fifo_ovf, frame_err;
  logic [CNT_W-1:0] press_cnt;

  ps2_key_tracker #(
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_ext(key_ext), .key_down(key_down), .press_cnt(press_cnt),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext),
    .evt_break(evt_break), .fifo_ovf(fifo_ovf), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_pops = 0;
  int          cyc = 0;
  int          kd_rise = -1;
  int          ev_rise = -1;
  logic        kd_prev = 1'b0;
  logic        ev_prev = 1'b0;
  logic [9:0]  exp_q [$];
  logic [10:0] sb_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    kd_prev <= key_down;
    ev_prev <= evt_valid;
    if (key_down && !kd_prev) kd_rise <= cyc;
    if (evt_valid && !ev_prev) ev_rise <= cyc;
  end

  always @(negedge clk) begin
    if (resetn && evt_valid && evt_ready) begin
      n_pops++;
      if (exp_q.size() != 0) sb_exp = {1'b1, exp_q.pop_front()};
      else sb_exp = 11'h000;
      check_val("evt", {21'd0, 1'b1, evt_ext, evt_break, evt_code}, {21'd0, sb_exp});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par);
    return {1'b1, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nb);
    for (int i = 0; i < nb; i++) begin
      ps2_data = f[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bits(mk_frame(d, 1'b0), 11);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(3);
    exp_q.delete();
    resetn = 1'b1;
    tick(3);
  endtask

  task automatic drain(input string tag, input int expect_pops);
    int p0;
    p0 = n_pops;
    evt_ready = 1'b1;
    for (int i = 0; i < 64 && evt_valid; i++) tick(1);
    evt_ready = 1'b0;
    check_val({tag, "_empty"}, evt_valid, 0);
    check_val({tag, "_pops"}, n_pops - p0, expect_pops);
    check_val({tag, "_sb"}, exp_q.size(), 0);
  endtask

  function automatic logic [30:0] all_outs();
    return {key_code, key_ext, key_down, press_cnt, evt_valid, evt_code,
            evt_ext, evt_break, fifo_ovf, frame_err};
  endfunction

  initial begin
    int p0;
    tick(3);
    check_val("rst_outs", all_outs(), 0);
    resetn = 1'b1;
    tick(3);

    // single make: key state one cycle before the FIFO head appears
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_byte(8'h1C);
    check_val("t1_code", key_code, 8'h1C);
    check_val("t1_down", key_down, 1);
    check_val("t1_ext", key_ext, 0);
    check_val("t1_cnt", press_cnt, 1);
    check_val("t1_valid", evt_valid, 1);
    check_val("t1_evt", {evt_ext, evt_break, evt_code}, {2'b00, 8'h1C});
    check_val("t1_lat", ev_rise - kd_rise, 1);

    // auto-repeat then break
`ifdef PS2_TYPEMATIC_EN
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
`endif
    exp_q.push_back({1'b0, 1'b1, 8'h1C});
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_val("t2_cnt", press_cnt, 1);
    check_val("t2_down", key_down, 0);
    check_val("t2_code", key_code, 8'h1C);
    drain("t2", T2_EVENTS);

    // extended make and extended break with the consumer always ready
    evt_ready = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 8'h75});
    send_byte(8'hE0);
    send_byte(8'h75);
    check_val("t3_ext", key_ext, 1);
    check_val("t3_code", key_code, 8'h75);
    check_val("t3_down", key_down, 1);
    check_val("t3_cnt", press_cnt, 2);
    exp_q.push_back({1'b1, 1'b1, 8'h75});
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    tick(5);
    check_val("t3_down_end", key_down, 0);
    check_val("t3_ext_end", key_ext, 1);
    check_val("t3_sb", exp_q.size(), 0);

    // parity error then a good frame
    p0 = n_pops;
    send_bits(mk_frame(8'h1C, 1'b1), 11);
    tick(5);
    check_val("t4_err", frame_err, 1);
    check_val("t4_cnt", press_cnt, 2);
    check_val("t4_nopop", n_pops - p0, 0);
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_byte(8'h1C);
    tick(5);
    check_val("t4_cnt2", press_cnt, 3);
    check_val("t4_code", key_code, 8'h1C);
    check_val("t4_sb", exp_q.size(), 0);
    evt_ready = 1'b0;

    // overflow, then simultaneous push and pop while full
    do_reset();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      if (i < FIFO_DEPTH) exp_q.push_back({1'b0, 1'b0, 8'h15 + 8'(i)});
      send_byte(8'h15 + 8'(i));
    end
    check_val("t5_ovf", fifo_ovf, 1);
    check_val("t5_cnt", press_cnt, FIFO_DEPTH + 1);
    check_val("t5_head", evt_code, 8'h15);
    exp_q.push_back({1'b0, 1'b0, 8'h40});
    fork
      send_byte(8'h40);
      begin
        for (int i = 0; i < 2000 && key_code != 8'h40; i++) tick(1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
      end
    join
    check_val("t5_seen", key_code, 8'h40);
    check_val("t5_full_valid", evt_valid, 1);
    check_val("t5_head2", evt_code, 8'h16);
    drain("t5", FIFO_DEPTH);
    check_val("t5_ovf_sticky", fifo_ovf, 1);

    // timeout mid-frame, recovery, then reset mid-frame
    do_reset();
    send_bits(mk_frame(8'h32, 1'b0), 5);
    check_val("t6_pre", frame_err, 0);
    tick(TIMEOUT_CYC + 20);
    check_val("t6_tmo", frame_err, 1);
    exp_q.push_back({1'b0, 1'b0, 8'h32});
    send_byte(8'h32);
    check_val("t6_code", key_code, 8'h32);
    check_val("t6_cnt", press_cnt, 1);
    drain("t6", 1);
    send_bits(mk_frame(8'h1C, 1'b0), 4);
    resetn = 1'b0;
    tick(2);
    check_val("t6_rst", all_outs(), 0);
    exp_q.delete();
    resetn = 1'b1;
    tick(3);
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_byte(8'h1C);
    check_val("t6_post_code", key_code, 8'h1C);
    check_val("t6_post_cnt", press_cnt, 1);
    check_val("t6_post_err", frame_err, 0);
    drain("t6b", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
